ride_dispatcher: RTL and testbench
==================================

// Module: ride_dispatcher
// PURPOSE
//  Consumer end of the waiting-queue counter: the ride side that removes riders from the queue.
//  Watches waiting-people count; when a full car can be seated, issues a drive request (-SEAT_CNT
//  command) to the queue counter with req/ack handshake, then sequences BOARD -> RIDE -> UNLOAD
//  on a prescaled tick. Shows phase on a 7-seg digit, counts completed rides.
// PARAMETERS
//  Q_W          5   width of queue_cnt (queue holds 0..20)
//  SEAT_CNT     8   riders removed per ride; also minimum queue_cnt to start
//  TICK_DIV     24  prescaler width; tick every 2**TICK_DIV clocks (tests use 2)
//  BOARD_TICKS  2   ticks spent in BOARD (>=1)
//  RIDE_TICKS   5   ticks spent in RIDE (>=1)
//  UNLOAD_TICKS 2   ticks spent in UNLOAD (>=1)
// PORTS
//  CLOCK_50    in   1     system clock, all state on rising edge
//  RESET_N     in   1     asynchronous, active-low reset
//  enable      in   1     operator run switch; 0 blocks new rides
//  queue_cnt   in   Q_W   current waiting people from queue counter
//  drive_req   out  1     request queue counter to subtract SEAT_CNT; held until acked
//  drive_ack   in   1     queue counter has applied the subtraction
//  ride_busy   out  1     1 in BOARD/RIDE/UNLOAD
//  state       out  3     current phase encoding (debug LEDs)
//  rides_done  out  8     completed-ride counter, wraps 255 -> 0
//  HEX_PHASE   out  [0:6] active-low 7-seg digit of state (0..4), bit 0 = segment a
// BEHAVIOUR
//  Reset (RESET_N=0, async): state=IDLE, drive_req=0, ride_busy=0, rides_done=0, HEX_PHASE=SEG0,
//   prescaler and phase timer cleared. Reset mid-operation aborts immediately, no ride counted.
//  States: IDLE=0, REQ=1, BOARD=2, RIDE=3, UNLOAD=4; codes 5..7 illegal -> next edge IDLE,
//   HEX_PHASE=SEG_BLANK while illegal.
//  IDLE: if enable && queue_cnt >= SEAT_CNT at an edge -> REQ; drive_req rises on that edge
//   (registered, 1-cycle latency). Otherwise stay. drive_ack ignored.
//  REQ: drive_req=1. drive_ack=1 at edge -> BOARD, drive_req=0 on same edge. enable=0 and
//   drive_ack=0 -> IDLE, drive_req=0 (abort, queue untouched). enable=0 with drive_ack=1: ack wins.
//   queue_cnt not rechecked in REQ.
//  Timed phases: on entry, prescaler cleared and timer loaded with phase tick count; tick = 1-cycle
//   pulse when prescaler wraps all-ones; timer decrements per tick; exit on tick with timer==1.
//   Each phase lasts exactly N*2**TICK_DIV clocks. BOARD -> RIDE -> UNLOAD -> IDLE.
//  UNLOAD exit: rides_done += 1 (modulo 256) on the transition edge.
//  enable=0 during BOARD/RIDE/UNLOAD ignored; ride completes. drive_ack outside REQ ignored.
//  At least one cycle in IDLE between rides; back-to-back rides allowed if condition still holds.
//  ride_busy, HEX_PHASE decoded from registered state (no glitch on comb inputs).
// STRUCTURE
//  ride_pkg: state codes (ST_IDLE..ST_UNLOAD), 7-seg constants SEG0..SEG9, SEG_BLANK=7'b111_1111,
//   segment encodings identical to the queue counter display (SEG0=7'b000_0001, SEG1=7'b100_1111...).
//  Sub-module tick_gen (CLOCK_50, RESET_N, clr, tick; param TICK_DIV): prescaler with sync clear.
//  Top: one FSM always block, phase timer, rides_done counter, 7-seg decode case.
// TESTING (TICK_DIV=2, BOARD=2, RIDE=3, UNLOAD=1 -> 8/12/4 clocks)
//  Reset asserted async mid-cycle -> state=0, drive_req=0, rides_done=0, HEX_PHASE=7'b000_0001.
//  enable=1, queue_cnt=8; ack 3 clocks after req -> req high 3 clocks, BOARD 8, RIDE 12,
//   UNLOAD 4 clocks, then IDLE with rides_done=1.
//  queue_cnt=4, enable=1, drive_ack pulsed -> stays IDLE, drive_req never rises.
//  In REQ drop enable, no ack -> IDLE next edge, drive_req=0; same with ack=1 -> BOARD.
//  RESET_N low during RIDE -> IDLE at once, rides_done unchanged-from-reset (0), no req.
//  256 rides with queue_cnt held at 20, ack immediate -> rides_done wraps to 0, 1 IDLE cycle each.

Source files
------------

// File: rtl/ride_dispatcher_pkg.sv
// Shared definitions for the ride dispatcher: phase encodings and the
// active-low 7-segment glyphs used by the queue counter display.
package ride_dispatcher_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_BOARD  = 3'd2,
    ST_RIDE   = 3'd3,
    ST_UNLOAD = 3'd4
  } state_t;

  // Index 0 is segment a; a 0 lights the segment.
  localparam logic [0:6] SEG0      = 7'b000_0001;
  localparam logic [0:6] SEG1      = 7'b100_1111;
  localparam logic [0:6] SEG2      = 7'b001_0010;
  localparam logic [0:6] SEG3      = 7'b000_0110;
  localparam logic [0:6] SEG4      = 7'b100_1100;
  localparam logic [0:6] SEG5      = 7'b010_0100;
  localparam logic [0:6] SEG6      = 7'b010_0000;
  localparam logic [0:6] SEG7      = 7'b000_1111;
  localparam logic [0:6] SEG8      = 7'b000_0000;
  localparam logic [0:6] SEG9      = 7'b000_0100;
  localparam logic [0:6] SEG_BLANK = 7'b111_1111;

endpackage

// File: rtl/ride_dispatcher_if.sv
// Handshake between the ride dispatcher (master) and the waiting-queue
// counter (slave) that applies the seat subtraction.
interface ride_dispatcher_if #(
  parameter int Q_W = 5
);
  logic [Q_W-1:0] queue_cnt;
  logic           drive_req;
  logic           drive_ack;

  modport master (
    input  queue_cnt,
    input  drive_ack,
    output drive_req
  );

  modport slave (
    output queue_cnt,
    output drive_ack,
    input  drive_req
  );
endinterface

// File: rtl/ride_dispatcher_tick_gen.sv
// Free-running prescaler; tick pulses for one clock each time the count
// sits at all-ones, and clr restarts the period from zero.
module tick_gen #(
  parameter int TICK_DIV = 24
) (
  input  logic CLOCK_50,
  input  logic RESET_N,
  input  logic clr,
  output logic tick
);

  logic [TICK_DIV-1:0] cnt;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + TICK_DIV'(1);
    end
  end

  assign tick = (cnt == '1);

endmodule

// File: rtl/ride_dispatcher.sv
// Ride-side consumer of the waiting queue: requests a full car's worth of
// riders, then runs BOARD -> RIDE -> UNLOAD on prescaled ticks.
//
// state  | meaning
// IDLE   | waiting for enable and a full car in the queue
// REQ    | drive_req held until the queue counter acks
// BOARD  | riders boarding, BOARD_TICKS ticks
// RIDE   | ride running, RIDE_TICKS ticks
// UNLOAD | riders leaving, UNLOAD_TICKS ticks; ride counted on exit
module ride_dispatcher
  import ride_dispatcher_pkg::*;
#(
  parameter int Q_W          = 5,
  parameter int SEAT_CNT     = 8,
  parameter int TICK_DIV     = 24,
  parameter int BOARD_TICKS  = 2,
  parameter int RIDE_TICKS   = 5,
  parameter int UNLOAD_TICKS = 2
) (
  input  logic                CLOCK_50,
  input  logic                RESET_N,
  input  logic                enable,
  ride_dispatcher_if.master   bus,
  output logic                ride_busy,
  output logic [2:0]          state,
  output logic [7:0]          rides_done,
  output logic [0:6]          HEX_PHASE
);

  localparam logic [Q_W-1:0] SEAT_Q    = Q_W'(SEAT_CNT);
  localparam logic [7:0]     BOARD_LD  = 8'(BOARD_TICKS);
  localparam logic [7:0]     RIDE_LD   = 8'(RIDE_TICKS);
  localparam logic [7:0]     UNLOAD_LD = 8'(UNLOAD_TICKS);

  state_t     cur_st;
  state_t     nxt_st;
  logic [7:0] timer;
  logic       tick;
  logic       clr;
  logic       phase_done;

  assign phase_done = tick && (timer == 8'd1);
  // Any phase change restarts the prescaler so each timed phase is exact.
  assign clr        = (nxt_st != cur_st);

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .CLOCK_50 (CLOCK_50),
    .RESET_N  (RESET_N),
    .clr      (clr),
    .tick     (tick)
  );

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      cur_st <= ST_IDLE;
    end else begin
      cur_st <= nxt_st;
    end
  end

  always_comb begin
    nxt_st = cur_st;
    case (cur_st)
      ST_IDLE: begin
        if (enable && (bus.queue_cnt >= SEAT_Q)) nxt_st = ST_REQ;
      end
      ST_REQ: begin
        // An ack in the same cycle as enable dropping still wins.
        if (bus.drive_ack)  nxt_st = ST_BOARD;
        else if (!enable)   nxt_st = ST_IDLE;
      end
      ST_BOARD:  if (phase_done) nxt_st = ST_RIDE;
      ST_RIDE:   if (phase_done) nxt_st = ST_UNLOAD;
      ST_UNLOAD: if (phase_done) nxt_st = ST_IDLE;
      default:   nxt_st = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      timer <= 8'd0;
    end else if (nxt_st != cur_st) begin
      case (nxt_st)
        ST_BOARD:  timer <= BOARD_LD;
        ST_RIDE:   timer <= RIDE_LD;
        ST_UNLOAD: timer <= UNLOAD_LD;
        default:   timer <= 8'd0;
      endcase
    end else if (tick && (timer != 8'd0)) begin
      timer <= timer - 8'd1;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      rides_done <= 8'd0;
    end else if ((cur_st == ST_UNLOAD) && (nxt_st == ST_IDLE)) begin
      rides_done <= rides_done + 8'd1;
    end
  end

  assign bus.drive_req = (cur_st == ST_REQ);
  assign ride_busy     = (cur_st == ST_BOARD) || (cur_st == ST_RIDE) ||
                         (cur_st == ST_UNLOAD);
  assign state         = cur_st;

  always_comb begin
    HEX_PHASE = SEG_BLANK;
    case (cur_st)
      ST_IDLE:   HEX_PHASE = SEG0;
      ST_REQ:    HEX_PHASE = SEG1;
      ST_BOARD:  HEX_PHASE = SEG2;
      ST_RIDE:   HEX_PHASE = SEG3;
      ST_UNLOAD: HEX_PHASE = SEG4;
      default:   HEX_PHASE = SEG_BLANK;
    endcase
  end

endmodule

// File: tb/tb_ride_dispatcher.sv
// Directed bench for ride_dispatcher with a scoreboard of expected
// rides_done values, checked whenever a ride finishes.
module tb_ride_dispatcher;

  localparam int Q_W = 5;
  localparam logic [0:6] H0 = 7'b000_0001;
  localparam logic [0:6] H1 = 7'b100_1111;
  localparam logic [0:6] H2 = 7'b001_0010;
  localparam logic [0:6] H3 = 7'b000_0110;
  localparam logic [0:6] H4 = 7'b100_1100;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       busy;
  logic [2:0] st;
  logic [7:0] rides;
  logic [0:6] hex;

  int passed = 0;
  int total  = 0;
  int sb[$];
  logic [2:0] prev_st = 3'd0;

  always #5 clk = ~clk;

  ride_dispatcher_if #(.Q_W(Q_W)) bus ();

  ride_dispatcher #(
    .Q_W(Q_W), .SEAT_CNT(8), .TICK_DIV(2),
    .BOARD_TICKS(2), .RIDE_TICKS(3), .UNLOAD_TICKS(1)
  ) dut (
    .CLOCK_50   (clk),
    .RESET_N    (rst_n),
    .enable     (enable),
    .bus        (bus),
    .ride_busy  (busy),
    .state      (st),
    .rides_done (rides),
    .HEX_PHASE  (hex)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic count_phase(input logic [2:0] ph, input int exp_len, input string tag);
    int n;
    n = 0;
    while (st == ph && n < 200) begin
      n++;
      @(negedge clk);
    end
    check(tag, n, exp_len);
  endtask

  // Scoreboard: a ride ends when UNLOAD hands back to IDLE.
  always @(negedge clk) begin
    if (prev_st == 3'd4 && st == 3'd0) begin
      if (sb.size() == 0) check("sb_underflow", 1, 0);
      else                check("rides_done_sb", rides, sb.pop_front());
    end
    prev_st <= st;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int n;
    int bad_idle;
    int timeouts;
    logic saw;

    rst_n = 1'b1; enable = 1'b0; bus.queue_cnt = '0; bus.drive_ack = 1'b0;

    // Async reset in the middle of a cycle
    @(negedge clk); #2 rst_n = 1'b0; #1;
    check("rst_state", st, 0);
    check("rst_req", bus.drive_req, 0);
    check("rst_rides", rides, 0);
    check("rst_hex", hex, H0);
    check("rst_busy", busy, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // Ride 1: ack three clocks after req
    enable = 1'b1; bus.queue_cnt = 5'd8; sb.push_back(1);
    @(negedge clk);
    check("req_state", st, 1);
    check("req_rise", bus.drive_req, 1);
    check("hex_req", hex, H1);
    @(negedge clk); check("req_hold2", bus.drive_req, 1);
    @(negedge clk); check("req_hold3", bus.drive_req, 1); bus.drive_ack = 1'b1;
    @(negedge clk);
    check("board_entry", st, 2);
    check("req_drop", bus.drive_req, 0);
    check("busy_board", busy, 1);
    check("hex_board", hex, H2);
    bus.drive_ack = 1'b0; bus.queue_cnt = 5'd0;
    count_phase(3'd2, 8, "board_len");
    check("hex_ride", hex, H3);
    count_phase(3'd3, 12, "ride_len");
    check("hex_unload", hex, H4);
    count_phase(3'd4, 4, "unload_len");
    check("idle_after_ride", st, 0);
    check("rides_after_1", rides, 1);
    check("busy_idle", busy, 0);

    // Below the seat threshold: acks are ignored, no request
    saw = 1'b0;
    for (int k = 0; k < 12; k++) begin
      bus.queue_cnt = (k < 6) ? 5'd4 : 5'd7;
      bus.drive_ack = ~bus.drive_ack;
      @(negedge clk);
      if (bus.drive_req !== 1'b0 || st !== 3'd0) saw = 1'b1;
    end
    check("below_seat_idle", saw, 0);
    bus.drive_ack = 1'b0;

    // Abort from REQ when enable drops without ack
    bus.queue_cnt = 5'd8;
    @(negedge clk); check("abort_req", st, 1);
    enable = 1'b0;
    @(negedge clk);
    check("abort_idle", st, 0);
    check("abort_req_low", bus.drive_req, 0);

    // Ack in the same cycle as enable drop wins; ride completes with enable low
    enable = 1'b1;
    @(negedge clk); check("ackwin_req", st, 1);
    enable = 1'b0; bus.drive_ack = 1'b1; sb.push_back(2);
    @(negedge clk); check("ack_wins", st, 2);
    bus.drive_ack = 1'b0; bus.queue_cnt = 5'd0;
    count_phase(3'd2, 8, "board_len2");
    count_phase(3'd3, 12, "ride_len2");
    count_phase(3'd4, 4, "unload_len2");
    check("rides_after_2", rides, 2);

    // Reset during RIDE aborts without counting
    enable = 1'b1; bus.queue_cnt = 5'd8;
    @(negedge clk); check("r3_req", st, 1);
    bus.drive_ack = 1'b1;
    @(negedge clk); check("r3_board", st, 2);
    bus.drive_ack = 1'b0; bus.queue_cnt = 5'd0; enable = 1'b0;
    count_phase(3'd2, 8, "board_len3");
    check("r3_ride", st, 3);
    @(negedge clk); @(negedge clk);
    #2 rst_n = 1'b0; #1;
    check("midride_rst_state", st, 0);
    check("midride_rst_rides", rides, 0);
    check("midride_rst_req", bus.drive_req, 0);
    check("midride_rst_busy", busy, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_idle", st, 0);
    check("post_rst_noreq", bus.drive_req, 0);

    // 256 back-to-back rides: counter wraps, one IDLE cycle between rides
    for (int k = 1; k <= 256; k++) sb.push_back(k % 256);
    bus.queue_cnt = 5'd20; bus.drive_ack = 1'b1; enable = 1'b1;
    bad_idle = 0; timeouts = 0;
    for (int r = 0; r < 256; r++) begin
      n = 0;
      while (st != 3'd4 && n < 100) begin n++; @(negedge clk); end
      if (n >= 100) timeouts++;
      n = 0;
      while (st == 3'd4 && n < 100) begin n++; @(negedge clk); end
      if (n >= 100) timeouts++;
      if (r == 255) begin
        enable = 1'b0;
      end else begin
        n = 0;
        while (st == 3'd0 && n < 50) begin n++; @(negedge clk); end
        if (n != 1) bad_idle++;
      end
    end
    bus.drive_ack = 1'b0;
    @(negedge clk); @(negedge clk);
    check("wrap_idle", st, 0);
    check("wrap_rides", rides, 0);
    check("wrap_idle_gap", bad_idle, 0);
    check("wrap_timeouts", timeouts, 0);
    check("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
